// File: rtl/spi_slave_core.sv
// SPI target endpoint: oversamples SCLK/CSn/MOSI in clk_i, shifts 8-bit MSB-first frames in
// modes 0-3, and exchanges bytes with the local side through TX/RX FIFOs with sticky error flags.
module spi_slave_core #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter logic [7:0]  UNDERRUN_BYTE = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cfg_en_i,
    input  logic       cfg_cpol_i,
    input  logic       cfg_cpha_i,
    input  logic       spi_sclk_i,
    input  logic       spi_csn_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic       spi_miso_oen_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_we_i,
    output logic       tx_full_o,
    output logic       tx_empty_o,
    output logic [7:0] rx_data_o,
    input  logic       rx_re_i,
    output logic       rx_full_o,
    output logic       rx_empty_o,
    output logic       rx_ovf_o,
    output logic       tx_unf_o,
    input  logic       clr_err_i,
    output logic       byte_done_o,
    output logic       busy_o
);
    localparam int unsigned BW  = 8;
    localparam int unsigned BCW = 3;
    localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW  = AW + 1;

    typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_csn_sync, r_mosi_sync;
    logic                   r_sclk_d, r_csn_d;
    logic                   w_sclk_s, w_csn_s, w_mosi_s;
    logic                   w_sclk_edge, w_lead, w_trail, w_sample_edge, w_shift_edge;
    logic                   w_csn_fall, w_csn_rise;

    state_t                 r_state, w_state_nxt;
    logic                   w_load, w_shift, w_sample, w_abort, w_last;

    logic [BCW-1:0]         r_bit_cnt;
    logic [BW-2:0]          r_rx_sh, r_tx_sh;
    logic                   r_miso, r_oen, r_busy, r_byte_done;
    logic                   r_rx_ovf, r_tx_unf;

    logic [BW-1:0]          r_tx_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_tx_wp, r_tx_rp;
    logic [CW-1:0]          r_tx_cnt, w_tx_cnt_nxt;
    logic                   r_tx_full, r_tx_empty, w_tx_push, w_tx_pop;
    logic [BW-1:0]          w_tx_byte;

    logic [BW-1:0]          r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_rx_wp, r_rx_rp;
    logic [CW-1:0]          r_rx_cnt, w_rx_cnt_nxt;
    logic                   r_rx_full, r_rx_empty, w_rx_push, w_rx_pop, w_rx_drop;
    logic [BW-1:0]          w_rx_byte;

    // Pin synchronizers followed by one-cycle edge detectors
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sclk_sync <= '0;
            r_csn_sync  <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_csn_d     <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
            r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], spi_csn_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            r_sclk_d    <= w_sclk_s;
            r_csn_d     <= w_csn_s;
        end
    end

    assign w_sclk_s      = r_sclk_sync[SYNC_STAGES-1];
    assign w_csn_s       = r_csn_sync[SYNC_STAGES-1];
    assign w_mosi_s      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_edge   = w_sclk_s ^ r_sclk_d;
    assign w_lead        = w_sclk_edge & (w_sclk_s != cfg_cpol_i);
    assign w_trail       = w_sclk_edge & (w_sclk_s == cfg_cpol_i);
    assign w_sample_edge = cfg_cpha_i ? w_trail : w_lead;
    assign w_shift_edge  = cfg_cpha_i ? w_lead : w_trail;
    assign w_csn_fall    = r_csn_d & ~w_csn_s;
    assign w_csn_rise    = ~r_csn_d & w_csn_s;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (cfg_en_i && w_csn_fall) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (!cfg_en_i || w_csn_rise) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Shift-engine strobes; edges seen while CSn is high are dropped here
    always_comb begin
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_sample = 1'b0;
        w_abort  = 1'b0;
        case (r_state)
            ST_IDLE: w_load = cfg_en_i & w_csn_fall & ~cfg_cpha_i;
            ST_ACTIVE: begin
                if (!cfg_en_i || w_csn_s) begin
                    w_abort = 1'b1;
                end else begin
                    w_sample = w_sample_edge;
                    w_load   = w_shift_edge & (r_bit_cnt == BCW'(0));
                    w_shift  = w_shift_edge & (r_bit_cnt != BCW'(0));
                end
            end
            default: w_abort = 1'b1;
        endcase
    end

    assign w_last    = w_sample & (r_bit_cnt == BCW'(7));
    assign w_rx_byte = {r_rx_sh, w_mosi_s};
    assign w_tx_byte = r_tx_empty ? UNDERRUN_BYTE : r_tx_mem[r_tx_rp];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_bit_cnt   <= '0;
            r_rx_sh     <= '0;
            r_tx_sh     <= '0;
            r_miso      <= 1'b0;
            r_oen       <= 1'b1;
            r_busy      <= 1'b0;
            r_byte_done <= 1'b0;
        end else begin
            r_byte_done <= w_last;
            r_busy      <= (w_state_nxt == ST_ACTIVE);
            r_oen       <= (w_state_nxt != ST_ACTIVE);
            if (w_abort || !cfg_en_i) begin
                r_bit_cnt <= '0;
            end else if (w_sample) begin
                r_bit_cnt <= r_bit_cnt + BCW'(1);
                r_rx_sh   <= {r_rx_sh[BW-3:0], w_mosi_s};
            end
            if (w_load) begin
                r_miso  <= w_tx_byte[BW-1];
                r_tx_sh <= w_tx_byte[BW-2:0];
            end else if (w_shift) begin
                r_miso  <= r_tx_sh[BW-2];
                r_tx_sh <= {r_tx_sh[BW-3:0], 1'b0};
            end
        end
    end

    // TX FIFO: pushed by the local side, popped at each byte load
    assign w_tx_pop  = w_load & ~r_tx_empty;
    assign w_tx_push = cfg_en_i & tx_we_i & (~r_tx_full | w_tx_pop);

    always_comb begin
        w_tx_cnt_nxt = r_tx_cnt;
        if (w_tx_push && !w_tx_pop)      w_tx_cnt_nxt = r_tx_cnt + CW'(1);
        else if (!w_tx_push && w_tx_pop) w_tx_cnt_nxt = r_tx_cnt - CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i || !cfg_en_i) begin
            r_tx_wp    <= '0;
            r_tx_rp    <= '0;
            r_tx_cnt   <= '0;
            r_tx_full  <= 1'b0;
            r_tx_empty <= 1'b1;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_full  <= (w_tx_cnt_nxt == CW'(FIFO_DEPTH));
            r_tx_empty <= (w_tx_cnt_nxt == CW'(0));
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= tx_data_i;
    end

    // RX FIFO: pushed on each completed byte, popped by the local side
    assign w_rx_pop  = cfg_en_i & rx_re_i & ~r_rx_empty;
    assign w_rx_push = w_last & (~r_rx_full | w_rx_pop);
    assign w_rx_drop = w_last & r_rx_full & ~w_rx_pop;

    always_comb begin
        w_rx_cnt_nxt = r_rx_cnt;
        if (w_rx_push && !w_rx_pop)      w_rx_cnt_nxt = r_rx_cnt + CW'(1);
        else if (!w_rx_push && w_rx_pop) w_rx_cnt_nxt = r_rx_cnt - CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i || !cfg_en_i) begin
            r_rx_wp    <= '0;
            r_rx_rp    <= '0;
            r_rx_cnt   <= '0;
            r_rx_full  <= 1'b0;
            r_rx_empty <= 1'b1;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_full  <= (w_rx_cnt_nxt == CW'(FIFO_DEPTH));
            r_rx_empty <= (w_rx_cnt_nxt == CW'(0));
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= w_rx_byte;
    end

    // Sticky error flags; a new error wins over a same-cycle clear
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i || !cfg_en_i) begin
            r_rx_ovf <= 1'b0;
            r_tx_unf <= 1'b0;
        end else begin
            if (w_rx_drop)                r_rx_ovf <= 1'b1;
            else if (clr_err_i)           r_rx_ovf <= 1'b0;
            if (w_load && r_tx_empty)     r_tx_unf <= 1'b1;
            else if (clr_err_i)           r_tx_unf <= 1'b0;
        end
    end

    assign spi_miso_o     = r_miso;
    assign spi_miso_oen_o = r_oen;
    assign tx_full_o      = r_tx_full;
    assign tx_empty_o     = r_tx_empty;
    assign rx_data_o      = r_rx_mem[r_rx_rp];
    assign rx_full_o      = r_rx_full;
    assign rx_empty_o     = r_rx_empty;
    assign rx_ovf_o       = r_rx_ovf;
    assign tx_unf_o       = r_tx_unf;
    assign byte_done_o    = r_byte_done;
    assign busy_o         = r_busy;

endmodule
